register_file_sb: RTL and testbench



---
 rtl/register_file_sb_pkg.sv | 10 +
 rtl/register_wport_mp.sv | 29 ++
 rtl/register_file_sb.sv | 116 +++++++++++
 tb/tb_register_file_sb.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared widths and types for the scoreboarded integer register file.
// Address type tracks the architectural register count.
package register_file_sb_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef logic [$clog2(NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/register_wport_mp.sv
// Priority write decode: per-register enable plus winning port index; purely combinational.
// On a same-address collision the highest-index port wins; register 0 never decodes.
module register_wport_mp #(
  parameter int N_REGS   = 32,
  parameter int N_WPORTS = 2,
  localparam int AW = $clog2(N_REGS),
  localparam int PW = (N_WPORTS > 1) ? $clog2(N_WPORTS) : 1
) (
  input  logic [N_WPORTS-1:0]         i_we,
  input  logic [N_WPORTS-1:0][AW-1:0] i_waddr,
  output logic [N_REGS-1:0]           o_reg_we,
  output logic [N_REGS-1:0][PW-1:0]   o_reg_sel
);

  // Ascending port scan so later (higher) ports overwrite earlier matches.
  always_comb begin
    o_reg_we  = '0;
    o_reg_sel = '0;
    for (int r = 1; r < N_REGS; r++) begin
      for (int p = 0; p < N_WPORTS; p++) begin
        if (i_we[p] && (i_waddr[p] == AW'(r))) begin
          o_reg_we[r]  = 1'b1;
          o_reg_sel[r] = PW'(p);
        end
      end
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with busy scoreboard; reads 0-cycle, writes/reservations land at the edge.
// Reservations stall via o_rsv_ready on a WAW hazard; trap drops all writes, reservations and busy bits.
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int N_REGS   = NUM_REGS,
  parameter int N_RPORTS = 2,
  parameter int N_WPORTS = 2,
  parameter int BYPASS   = 1,
  localparam int AW = $clog2(N_REGS),
  localparam int CW = $clog2(N_REGS + 1),
  localparam int PW = (N_WPORTS > 1) ? $clog2(N_WPORTS) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [N_WPORTS-1:0]            i_we,
  input  logic [N_WPORTS-1:0][AW-1:0]    i_waddr,
  input  logic [N_WPORTS-1:0][XLEN-1:0]  i_wdata,
  input  logic [N_RPORTS-1:0][AW-1:0]    i_raddr,
  output logic [N_RPORTS-1:0][XLEN-1:0]  o_rdata,
  output logic [N_RPORTS-1:0]            o_rbusy,
  input  logic                           i_rsv_valid,
  input  logic [AW-1:0]                  i_rsv_addr,
  output logic                           o_rsv_ready,
  input  logic                           i_trap_req,
  output logic [CW-1:0]                  o_busy_cnt
);

  logic [XLEN-1:0]          regs_q [N_REGS];
  logic [N_REGS-1:0]        busy_q, busy_d;
  logic [CW-1:0]            busy_cnt_q, busy_cnt_d;
  logic [N_WPORTS-1:0]      eff_we;
  logic [N_REGS-1:0]        reg_we;
  logic [N_REGS-1:0][PW-1:0] reg_sel;
  logic                     rsv_acc;

  // A trap kills every write before decode, so bypass and release see it too.
  assign eff_we = i_we & {N_WPORTS{~i_trap_req}};

  register_wport_mp #(
    .N_REGS   (N_REGS),
    .N_WPORTS (N_WPORTS)
  ) u_wport (
    .i_we      (eff_we),
    .i_waddr   (i_waddr),
    .o_reg_we  (reg_we),
    .o_reg_sel (reg_sel)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < N_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < N_REGS; r++) begin
        if (reg_we[r]) begin
          regs_q[r] <= i_wdata[reg_sel[r]];
        end
      end
    end
  end

  always_comb begin
    o_rsv_ready = (i_rsv_addr == '0) || !busy_q[i_rsv_addr] || reg_we[i_rsv_addr];
  end

  assign rsv_acc = i_rsv_valid && o_rsv_ready && !i_trap_req;

  // Release first, then set, so a same-cycle release+reserve leaves the bit busy.
  always_comb begin
    busy_d = busy_q & ~reg_we;
    if (rsv_acc && (i_rsv_addr != '0)) begin
      busy_d[i_rsv_addr] = 1'b1;
    end
    if (i_trap_req) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < N_REGS; r++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign o_busy_cnt = busy_cnt_q;

  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    for (int q = 0; q < N_RPORTS; q++) begin
      if (i_raddr[q] != '0) begin
        if ((BYPASS != 0) && reg_we[i_raddr[q]]) begin
          o_rdata[q] = i_wdata[reg_sel[i_raddr[q]]];
        end else begin
          o_rdata[q] = regs_q[i_raddr[q]];
          o_rbusy[q] = busy_q[i_raddr[q]];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: reset sweep, per-cycle vector table, mid-run async reset.
module tb_register_file_sb;
  import register_file_sb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            we;
  logic [1:0][4:0]       waddr;
  logic [1:0][31:0]      wdata;
  logic [1:0][4:0]       raddr;
  logic [1:0][31:0]      rdata;
  logic [1:0]            rbusy;
  logic                  rsv_valid;
  logic [4:0]            rsv_addr;
  logic                  rsv_ready;
  logic                  trap;
  logic [5:0]            busy_cnt;

  int checks   = 0;
  int failures = 0;

  register_file_sb dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_we        (we),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .i_raddr     (raddr),
    .o_rdata     (rdata),
    .o_rbusy     (rbusy),
    .i_rsv_valid (rsv_valid),
    .i_rsv_addr  (rsv_addr),
    .o_rsv_ready (rsv_ready),
    .i_trap_req  (trap),
    .o_busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    reg_addr_t   wa0;
    logic [31:0] wd0;
    reg_addr_t   wa1;
    logic [31:0] wd1;
    reg_addr_t   ra0;
    reg_addr_t   ra1;
    logic        rv;
    reg_addr_t   radr;
    logic        trap;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rb;
    logic        e_rdy;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; raddr = '0;
    rsv_valid = 1'b0; rsv_addr = '0; trap = 1'b0;
  endtask

  function automatic vec_t mk(logic [1:0] w, reg_addr_t a0, logic [31:0] d0, reg_addr_t a1,
                              logic [31:0] d1, reg_addr_t r0, reg_addr_t r1, logic v,
                              reg_addr_t ra, logic t, logic [31:0] x0, logic [31:0] x1,
                              logic [1:0] b, logic y, logic [5:0] c);
    vec_t s;
    s.we = w; s.wa0 = a0; s.wd0 = d0; s.wa1 = a1; s.wd1 = d1;
    s.ra0 = r0; s.ra1 = r1; s.rv = v; s.radr = ra; s.trap = t;
    s.e_rd0 = x0; s.e_rd1 = x1; s.e_rb = b; s.e_rdy = y; s.e_cnt = c;
    return s;
  endfunction

  initial begin
    //            we     wa0 wd0           wa1 wd1           ra0 ra1 rv  radr trap  rd0           rd1           rb     rdy   cnt
    vecs[0]  = mk(2'b11, 5, 32'hAAAA0000,  5, 32'h12345678,  5,  0, 0,  0,  0, 32'h12345678, 32'h0,        2'b00, 1'b1, 6'd0);
    vecs[1]  = mk(2'b00, 0, 32'h0,         0, 32'h0,         5,  5, 1,  7,  0, 32'h12345678, 32'h12345678, 2'b00, 1'b1, 6'd0);
    vecs[2]  = mk(2'b00, 0, 32'h0,         0, 32'h0,         7,  5, 1,  7,  0, 32'h0,        32'h12345678, 2'b01, 1'b0, 6'd1);
    vecs[3]  = mk(2'b01, 7, 32'h77,        0, 32'h0,         7,  0, 0,  7,  0, 32'h77,       32'h0,        2'b00, 1'b1, 6'd1);
    vecs[4]  = mk(2'b00, 0, 32'h0,         0, 32'h0,         7,  0, 1,  9,  0, 32'h77,       32'h0,        2'b00, 1'b1, 6'd0);
    vecs[5]  = mk(2'b00, 0, 32'h0,         0, 32'h0,         9,  0, 1,  9,  0, 32'h0,        32'h0,        2'b01, 1'b0, 6'd1);
    vecs[6]  = mk(2'b10, 0, 32'h0,         9, 32'h99,        9,  0, 1,  9,  0, 32'h99,       32'h0,        2'b00, 1'b1, 6'd1);
    vecs[7]  = mk(2'b00, 0, 32'h0,         0, 32'h0,         9,  0, 1,  3,  0, 32'h99,       32'h0,        2'b01, 1'b1, 6'd1);
    vecs[8]  = mk(2'b00, 0, 32'h0,         0, 32'h0,         3,  0, 1,  4,  0, 32'h0,        32'h0,        2'b01, 1'b1, 6'd2);
    vecs[9]  = mk(2'b01, 3, 32'hDEAD,      0, 32'h0,         3,  4, 0,  0,  1, 32'h0,        32'h0,        2'b11, 1'b1, 6'd3);
    vecs[10] = mk(2'b01, 0, 32'hFFFFFFFF,  0, 32'h0,         3,  9, 1,  0,  0, 32'h0,        32'h99,       2'b00, 1'b1, 6'd0);
    vecs[11] = mk(2'b00, 0, 32'h0,         0, 32'h0,         0,  0, 1,  7,  0, 32'h0,        32'h0,        2'b00, 1'b1, 6'd0);
    vecs[12] = mk(2'b10, 0, 32'h0,        12, 32'h1200,      7, 12, 0,  0,  0, 32'h77,       32'h1200,     2'b01, 1'b1, 6'd1);
    vecs[13] = mk(2'b00, 0, 32'h0,         0, 32'h0,        12,  7, 0,  0,  0, 32'h1200,     32'h77,       2'b10, 1'b1, 6'd1);

    idle();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;

    // Post-reset sweep of every address on both read ports
    for (int a = 0; a < 32; a++) begin
      raddr[0] = 5'(a); raddr[1] = 5'(31 - a); rsv_addr = 5'(a);
      #1;
      check($sformatf("reset_rdata0[%0d]", a), rdata[0], 32'h0);
      check($sformatf("reset_rdata1[%0d]", 31 - a), rdata[1], 32'h0);
      check($sformatf("reset_rbusy[%0d]", a), {30'd0, rbusy}, 32'h0);
      check($sformatf("reset_rsv_ready[%0d]", a), {31'd0, rsv_ready}, 32'h1);
    end
    check("reset_busy_cnt", {26'd0, busy_cnt}, 32'h0);

    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      we = vecs[i].we;
      waddr[0] = vecs[i].wa0; wdata[0] = vecs[i].wd0;
      waddr[1] = vecs[i].wa1; wdata[1] = vecs[i].wd1;
      raddr[0] = vecs[i].ra0; raddr[1] = vecs[i].ra1;
      rsv_valid = vecs[i].rv; rsv_addr = vecs[i].radr; trap = vecs[i].trap;
      @(negedge clk);
      check($sformatf("v%0d_rdata0", i), rdata[0], vecs[i].e_rd0);
      check($sformatf("v%0d_rdata1", i), rdata[1], vecs[i].e_rd1);
      check($sformatf("v%0d_rbusy", i), {30'd0, rbusy}, {30'd0, vecs[i].e_rb});
      check($sformatf("v%0d_rsv_ready", i), {31'd0, rsv_ready}, {31'd0, vecs[i].e_rdy});
      check($sformatf("v%0d_busy_cnt", i), {26'd0, busy_cnt}, {26'd0, vecs[i].e_cnt});
      @(posedge clk); #1;
    end

    // Mid-cycle asynchronous reset: x7 busy, x5/x7/x12 hold data
    idle();
    raddr[0] = 5'd7; raddr[1] = 5'd12; rsv_addr = 5'd7;
    #1;
    check("pre_rst_rbusy7", {31'd0, rbusy[0]}, 32'h1);
    check("pre_rst_rsv_ready7", {31'd0, rsv_ready}, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy_cnt", {26'd0, busy_cnt}, 32'h0);
    check("rst_rbusy", {30'd0, rbusy}, 32'h0);
    check("rst_rdata_x7", rdata[0], 32'h0);
    check("rst_rdata_x12", rdata[1], 32'h0);
    check("rst_rsv_ready7", {31'd0, rsv_ready}, 32'h1);
    raddr[0] = 5'd5;
    #1;
    check("rst_rdata_x5", rdata[0], 32'h0);
    rst_n = 1'b1;

    // Two ports writing distinct registers in one cycle, then read both back
    @(posedge clk); #1;
    we = 2'b11; waddr[0] = 5'd20; wdata[0] = 32'hCAFE0020; waddr[1] = 5'd21; wdata[1] = 32'hBEEF0021;
    @(posedge clk); #1;
    idle();
    raddr[0] = 5'd20; raddr[1] = 5'd21;
    @(negedge clk);
    check("dual_write_x20", rdata[0], 32'hCAFE0020);
    check("dual_write_x21", rdata[1], 32'hBEEF0021);
    check("post_rst_busy_cnt", {26'd0, busy_cnt}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
